// File: rtl/pixel_pos.sv
// rtl/pixel_pos.sv - serpentine pixel position generator with latched scan bounds
module pixel_pos #(
  parameter int X_MAX = 7,
  parameter int Y_MAX = 8,
  localparam int XW = $clog2(X_MAX),
  localparam int YW = $clog2(Y_MAX)
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic          update_pos,
  input  logic          new_trans,
  input  logic [XW-1:0] max_x,
  input  logic [YW-1:0] max_y,
  output logic          end_pos,
  output logic          next_dir,
  output logic [XW-1:0] curr_x,
  output logic [YW-1:0] curr_y
);

  localparam logic [XW-1:0] X_ONE = XW'(1);
  localparam logic [YW-1:0] Y_ONE = YW'(1);

  logic [XW-1:0] lim_x_q, lim_x_d;
  logic [YW-1:0] lim_y_q, lim_y_d;
  logic [XW-1:0] curr_x_q, curr_x_d;
  logic [YW-1:0] curr_y_q, curr_y_d;
  logic          dir_q, dir_d;
  logic          next_dir_q, next_dir_d;

  logic          row_end;

  // Row end is the last x of the current traversal direction; the scan ends at the row end of the last row
  always_comb begin
    row_end = dir_q ? (curr_x_q == '0) : (curr_x_q == lim_x_q);
    end_pos = (curr_y_q == lim_y_q) && row_end;
  end

  // Next-state: new_trans restarts the scan, update_pos steps along x or turns onto the next row
  always_comb begin
    lim_x_d    = lim_x_q;
    lim_y_d    = lim_y_q;
    curr_x_d   = curr_x_q;
    curr_y_d   = curr_y_q;
    dir_d      = dir_q;
    next_dir_d = 1'b0;
    if (new_trans) begin
      lim_x_d  = max_x;
      lim_y_d  = max_y;
      curr_x_d = '0;
      curr_y_d = '0;
      dir_d    = 1'b0;
    end else if (update_pos && !end_pos) begin
      if (!row_end) begin
        curr_x_d = dir_q ? (curr_x_q - X_ONE) : (curr_x_q + X_ONE);
      end else begin
        curr_y_d   = curr_y_q + Y_ONE;
        dir_d      = ~dir_q;
        next_dir_d = 1'b1;
      end
    end
  end

  // State registers with synchronous active-low reset taking priority over every command
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      lim_x_q    <= '0;
      lim_y_q    <= '0;
      curr_x_q   <= '0;
      curr_y_q   <= '0;
      dir_q      <= 1'b0;
      next_dir_q <= 1'b0;
    end else begin
      lim_x_q    <= lim_x_d;
      lim_y_q    <= lim_y_d;
      curr_x_q   <= curr_x_d;
      curr_y_q   <= curr_y_d;
      dir_q      <= dir_d;
      next_dir_q <= next_dir_d;
    end
  end

  assign curr_x   = curr_x_q;
  assign curr_y   = curr_y_q;
  assign next_dir = next_dir_q;

endmodule

// File: tb/tb_pixel_pos.sv
// tb/tb_pixel_pos.sv - randomized self-checking bench for pixel_pos against a position-list model
module tb_pixel_pos;

  logic       clk;
  logic       n_rst;
  logic       update_pos;
  logic       new_trans;
  logic [2:0] max_x;
  logic [2:0] max_y;
  logic       end_pos;
  logic       next_dir;
  logic [2:0] curr_x;
  logic [2:0] curr_y;

  int checks;
  int failures;

  // Model: the whole scan is an explicit list of (x,y) positions; idx points at the current one
  int q_x[$];
  int q_y[$];
  int idx;
  bit m_nd;

  pixel_pos #(.X_MAX(7), .Y_MAX(8)) dut (
    .clk(clk),
    .n_rst(n_rst),
    .update_pos(update_pos),
    .new_trans(new_trans),
    .max_x(max_x),
    .max_y(max_y),
    .end_pos(end_pos),
    .next_dir(next_dir),
    .curr_x(curr_x),
    .curr_y(curr_y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_load(input int mx, input int my);
    q_x.delete();
    q_y.delete();
    for (int y = 0; y <= my; y++) begin
      if (y % 2 == 0) begin
        for (int x = 0; x <= mx; x++) begin q_x.push_back(x); q_y.push_back(y); end
      end else begin
        for (int x = mx; x >= 0; x--) begin q_x.push_back(x); q_y.push_back(y); end
      end
    end
    idx  = 0;
    m_nd = 1'b0;
  endtask

  function automatic logic [7:0] exp_vec();
    return {3'(q_x[idx]), 3'(q_y[idx]), (idx == q_x.size() - 1), m_nd};
  endfunction

  // One clock: drive inputs, step the model on the edge, settle 1 time unit after
  task automatic cycle(input bit rst, input bit nt, input bit upd, input int mx, input int my);
    n_rst      = rst;
    new_trans  = nt;
    update_pos = upd;
    max_x      = 3'(mx);
    max_y      = 3'(my);
    @(posedge clk);
    if (!rst) model_load(0, 0);
    else if (nt) model_load(mx, my);
    else if (upd && idx < q_x.size() - 1) begin
      m_nd = (q_y[idx + 1] != q_y[idx]);
      idx++;
    end else m_nd = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    cycle(0, 0, 0, 0, 0);
    cycle(0, 1, 1, 5, 5);
    checks++;
    if ({curr_x, curr_y, end_pos, next_dir} !== {3'd0, 3'd0, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL reset: got x=%0d y=%0d end=%0b nd=%0b want 0 0 1 0", curr_x, curr_y, end_pos, next_dir);
    end
  endtask

  task automatic test_full_scan();
    int pulses;
    pulses = 0;
    cycle(1, 1, 0, 5, 5);
    for (int i = 0; i < 40; i++) begin
      cycle(1, 0, 1, 0, 0);
      if (next_dir === 1'b1) pulses++;
      checks++;
      if ({curr_x, curr_y, end_pos, next_dir} !== exp_vec()) begin
        failures++;
        $display("FAIL full_scan[%0d]: got %b want %b", i, {curr_x, curr_y, end_pos, next_dir}, exp_vec());
      end
    end
    checks++;
    if (pulses != 5 || {curr_x, curr_y, end_pos} !== {3'd0, 3'd5, 1'b1}) begin
      failures++;
      $display("FAIL full_scan_end: got pulses=%0d x=%0d y=%0d end=%0b want 5 0 5 1", pulses, curr_x, curr_y, end_pos);
    end
  endtask

  task automatic test_one_column();
    cycle(1, 1, 0, 0, 3);
    for (int i = 1; i <= 3; i++) begin
      cycle(1, 0, 1, 0, 0);
      checks++;
      if ({curr_x, curr_y, end_pos, next_dir} !== {3'd0, 3'(i), (i == 3), 1'b1}) begin
        failures++;
        $display("FAIL one_column[%0d]: got x=%0d y=%0d end=%0b nd=%0b want 0 %0d %0b 1",
                 i, curr_x, curr_y, end_pos, next_dir, i, (i == 3));
      end
    end
    cycle(1, 0, 1, 0, 0);
    checks++;
    if ({curr_x, curr_y, end_pos, next_dir} !== {3'd0, 3'd3, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL one_column_hold: got x=%0d y=%0d end=%0b nd=%0b want 0 3 1 0", curr_x, curr_y, end_pos, next_dir);
    end
  endtask

  task automatic test_mid_abort();
    int ex[5] = '{1, 2, 2, 1, 0};
    int ey[5] = '{0, 0, 1, 1, 1};
    cycle(1, 1, 0, 5, 5);
    for (int i = 0; i < 15; i++) cycle(1, 0, 1, 0, 0);
    checks++;
    if ({curr_x, curr_y} !== {3'd3, 3'd2}) begin
      failures++;
      $display("FAIL abort_pre: got x=%0d y=%0d want 3 2", curr_x, curr_y);
    end
    cycle(1, 1, 1, 2, 1);
    checks++;
    if ({curr_x, curr_y, end_pos, next_dir} !== {3'd0, 3'd0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL abort_restart: got x=%0d y=%0d end=%0b nd=%0b want 0 0 0 0", curr_x, curr_y, end_pos, next_dir);
    end
    for (int i = 0; i < 5; i++) begin
      cycle(1, 0, 1, 0, 0);
      checks++;
      if ({curr_x, curr_y, end_pos} !== {3'(ex[i]), 3'(ey[i]), (i == 4)}) begin
        failures++;
        $display("FAIL abort_walk[%0d]: got x=%0d y=%0d end=%0b want %0d %0d %0b",
                 i, curr_x, curr_y, end_pos, ex[i], ey[i], (i == 4));
      end
    end
  endtask

  task automatic test_toggle();
    cycle(1, 1, 0, 2, 2);
    for (int i = 0; i < 16; i++) begin
      cycle(1, 0, (i % 2 == 0), 0, 0);
      checks++;
      if ({curr_x, curr_y, end_pos, next_dir} !== exp_vec()) begin
        failures++;
        $display("FAIL toggle[%0d]: got %b want %b", i, {curr_x, curr_y, end_pos, next_dir}, exp_vec());
      end
    end
    checks++;
    if ({curr_x, curr_y, end_pos} !== {3'd2, 3'd2, 1'b1}) begin
      failures++;
      $display("FAIL toggle_end: got x=%0d y=%0d end=%0b want 2 2 1", curr_x, curr_y, end_pos);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      bit rst, nt, upd;
      rst = ($urandom_range(0, 99) != 0);
      nt  = ($urandom_range(0, 39) == 0);
      upd = ($urandom_range(0, 3) != 0);
      cycle(rst, nt, upd, $urandom_range(0, 7), $urandom_range(0, 7));
      checks++;
      if ({curr_x, curr_y, end_pos, next_dir} !== exp_vec()) begin
        failures++;
        $display("FAIL random[%0d]: got %b want %b", i, {curr_x, curr_y, end_pos, next_dir}, exp_vec());
      end
    end
  endtask

  task automatic test_reset_override();
    cycle(1, 1, 0, 4, 4);
    for (int i = 0; i < 7; i++) cycle(1, 0, 1, 0, 0);
    cycle(0, 1, 1, 5, 5);
    checks++;
    if ({curr_x, curr_y, end_pos, next_dir} !== {3'd0, 3'd0, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL reset_override: got x=%0d y=%0d end=%0b nd=%0b want 0 0 1 0", curr_x, curr_y, end_pos, next_dir);
    end
    cycle(1, 0, 1, 0, 0);
    checks++;
    if ({curr_x, curr_y, end_pos, next_dir} !== {3'd0, 3'd0, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL reset_no_latch: got x=%0d y=%0d end=%0b nd=%0b want 0 0 1 0", curr_x, curr_y, end_pos, next_dir);
    end
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    n_rst      = 1'b0;
    new_trans  = 1'b0;
    update_pos = 1'b0;
    max_x      = 3'd0;
    max_y      = 3'd0;
    model_load(0, 0);
    test_reset();
    test_full_scan();
    test_one_column();
    test_mid_abort();
    test_toggle();
    test_random();
    test_reset_override();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pixel_pos.md
PIXEL_POS -- requirements
Module: pixel_pos

Interface
REQ-001 Parameter X_MAX, default 7: upper bound on the x extent; XW = $clog2(X_MAX) bits for x signals.
REQ-002 Parameter Y_MAX, default 8: upper bound on the y extent; YW = $clog2(Y_MAX) bits for y signals.
REQ-003 clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 n_rst  input  1  reset; synchronous and active-low.
REQ-005 update_pos  input  1  advance one position this cycle when high.
REQ-006 new_trans  input  1  start a new scan: latch bounds, return to origin.
REQ-007 max_x  input  XW  last valid x index (inclusive), sampled only on new_trans.
REQ-008 max_y  input  YW  last valid y index (inclusive), sampled only on new_trans.
REQ-009 end_pos  output  1  current position is the final position of the scan.
REQ-010 next_dir  output  1  one-cycle pulse: previous update moved to a new row (direction reversed).
REQ-011 curr_x  output  XW  current x position.
REQ-012 curr_y  output  YW  current y position.

Function
REQ-013 The block SHALL keep registered state lim_x (XW), lim_y (YW), curr_x, curr_y, dir (0 = x increasing, 1 = x decreasing) and a next_dir register.
REQ-014 The scan SHALL be serpentine: even rows traverse x 0->lim_x, odd rows traverse x lim_x->0, rows advance y 0->lim_y.
REQ-015 Priority per cycle SHALL be: n_rst low > new_trans > update_pos > hold.
REQ-016 On new_trans=1: lim_x<=max_x, lim_y<=max_y, curr_x<=0, curr_y<=0, dir<=0, next_dir<=0; update_pos ignored that cycle.
REQ-017 On update_pos=1 with end_pos=0 and not at row end (dir=0 and curr_x<lim_x, or dir=1 and curr_x>0): curr_x SHALL step +1 (dir=0) or -1 (dir=1); curr_y unchanged; next_dir<=0.
REQ-018 On update_pos=1 with end_pos=0 at row end (dir=0 and curr_x==lim_x, or dir=1 and curr_x==0): curr_y<=curr_y+1, curr_x unchanged, dir<=~dir, next_dir<=1.
REQ-019 On update_pos=1 with end_pos=1: all state SHALL hold (no wrap, no overflow); next_dir<=0.
REQ-020 With update_pos=0 and new_trans=0: all state SHALL hold; next_dir<=0.
REQ-021 next_dir SHALL be high for exactly one cycle per row change, in the cycle after the advancing edge.
REQ-022 end_pos SHALL be combinational from registers: 1 iff curr_y==lim_y and curr_x==(dir ? 0 : lim_x).
REQ-023 Latency: curr_x/curr_y SHALL reflect an update on the edge where update_pos is sampled high (1 cycle).
REQ-024 curr_x SHALL never exceed lim_x and curr_y never exceed lim_y; max_x/max_y wider values are truncated to XW/YW by the driver.
REQ-025 Bounds of 0 SHALL be legal: lim_x=0 gives a one-column scan (every update changes row); lim_x=lim_y=0 gives end_pos=1 immediately.
REQ-026 new_trans mid-scan SHALL abort the scan and restart at (0,0) with the new bounds.

Reset
REQ-027 On a rising edge with n_rst=0: curr_x=0, curr_y=0, lim_x=0, lim_y=0, dir=0, next_dir=0; end_pos therefore reads 1 until a new_trans with nonzero bounds.
REQ-028 Reset mid-scan SHALL override new_trans and update_pos in the same cycle.

Verification
REQ-029 Reset, then outputs -> curr_x=0, curr_y=0, next_dir=0, end_pos=1.
REQ-030 new_trans with max_x=5,max_y=5, update_pos held 40 cycles -> (0..5,0), (5,1)..(0,1), ..., final (0,5) after 35 updates; end_pos=1 from then on, position holds; next_dir pulses exactly 5 times.
REQ-031 max_x=0,max_y=3, update_pos continuous -> positions (0,0),(0,1),(0,2),(0,3); next_dir high 3 consecutive cycles; end_pos=1 at (0,3).
REQ-032 Mid-scan (e.g. at (3,2)) assert new_trans with max_x=2,max_y=1 and update_pos=1 -> next cycle (0,0), dir=0; then (1,0),(2,0),(2,1),(1,1),(0,1), end_pos=1.
REQ-033 update_pos toggled 1/0 alternately with max_x=max_y=2 -> position advances only on cycles with update_pos=1; 8 advances reach (2,2) with end_pos=1.
REQ-034 Reset asserted with new_trans=1 and update_pos=1 -> reset state of REQ-027, bounds not latched.
